// File: rtl/lcd_power_seq.sv
// HD44780-style character LCD power/init sequencer with a valid/ready byte-write port.
// Optional backlight output lcd_blon is enabled by defining LCD_BACKLIGHT_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// OFF     | panel unpowered, every output (including the bus) held 0
// POWERUP | lcd_on high, waiting POWERUP_CYC before the first write
// SETUP   | one cycle with rs/data on the bus, strobe low
// STROBE  | lcd_en high for EN_HIGH_CYC cycles
// GAP     | strobe low, rs/data held, post-write execution wait
// READY   | init complete, accepting one byte write per handshake
module lcd_power_seq #(
  parameter int POWERUP_CYC  = 750000,
  parameter int EN_HIGH_CYC  = 12,
  parameter int CMD_GAP_CYC  = 2000,
  parameter int LONG_GAP_CYC = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_on_req,
  input  logic       cmd_valid,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       init_done,
  output logic       lcd_on,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic       lcd_rw,
`ifdef LCD_BACKLIGHT_EN
  output logic       lcd_blon,
`endif
  output logic [7:0] lcd_data
);

  localparam int MAX_A   = (POWERUP_CYC > EN_HIGH_CYC) ? POWERUP_CYC : EN_HIGH_CYC;
  localparam int MAX_B   = (CMD_GAP_CYC > LONG_GAP_CYC) ? CMD_GAP_CYC : LONG_GAP_CYC;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] PWR_LD  = CW'(POWERUP_CYC - 1);
  localparam logic [CW-1:0] EN_LD   = CW'(EN_HIGH_CYC - 1);
  localparam logic [CW-1:0] CMD_LD  = CW'(CMD_GAP_CYC - 1);
  localparam logic [CW-1:0] LONG_LD = CW'(LONG_GAP_CYC - 1);

  // idx_q == INIT_END marks a fully initialised panel
  localparam logic [2:0] INIT_END = 3'd4;

  typedef enum logic [2:0] {
    S_OFF,
    S_POWERUP,
    S_SETUP,
    S_STROBE,
    S_GAP,
    S_READY
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    data_q, data_d;
  logic          rs_q, rs_d;
  logic          long_q, long_d;
  logic [2:0]    idx_nxt;

  function automatic logic [7:0] init_byte(input logic [2:0] i);
    case (i)
      3'd0:    init_byte = 8'h38;
      3'd1:    init_byte = 8'h0C;
      3'd2:    init_byte = 8'h01;
      default: init_byte = 8'h06;
    endcase
  endfunction

  // clear display and return home need the long execution wait
  function automatic logic is_long(input logic rs, input logic [7:0] d);
    is_long = !rs && ((d == 8'h01) || (d == 8'h02));
  endfunction

  assign idx_nxt = idx_q + 3'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      rs_q    <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      long_q  <= long_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    rs_d    = rs_q;
    long_d  = long_q;

    case (state_q)
      S_OFF: begin
        cnt_d  = '0;
        idx_d  = '0;
        data_d = '0;
        rs_d   = 1'b0;
        long_d = 1'b0;
        if (lcd_on_req) begin
          state_d = S_POWERUP;
          cnt_d   = PWR_LD;
        end
      end
      S_POWERUP: begin
        if (cnt_q == '0) begin
          state_d = S_SETUP;
          data_d  = init_byte(3'd0);
          rs_d    = 1'b0;
          long_d  = is_long(1'b0, init_byte(3'd0));
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
        cnt_d   = EN_LD;
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = long_q ? LONG_LD : CMD_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (idx_q == INIT_END) begin
          state_d = S_READY;
        end else if (idx_nxt == INIT_END) begin
          state_d = S_READY;
          idx_d   = idx_nxt;
        end else begin
          state_d = S_SETUP;
          idx_d   = idx_nxt;
          data_d  = init_byte(idx_nxt);
          rs_d    = 1'b0;
          long_d  = is_long(1'b0, init_byte(idx_nxt));
        end
      end
      S_READY: begin
        if (cmd_valid) begin
          state_d = S_SETUP;
          data_d  = cmd_data;
          rs_d    = cmd_rs;
          long_d  = is_long(cmd_rs, cmd_data);
        end
      end
      default: state_d = S_OFF;
    endcase

    // power-down request wins over everything, aborting any write in flight
    if (!lcd_on_req) begin
      state_d = S_OFF;
      cnt_d   = '0;
      idx_d   = '0;
      data_d  = '0;
      rs_d    = 1'b0;
      long_d  = 1'b0;
    end
  end

  assign cmd_ready = (state_q == S_READY);
  assign init_done = (idx_q == INIT_END);
  assign lcd_on    = (state_q != S_OFF);
  assign lcd_en    = (state_q == S_STROBE);
  assign lcd_rs    = rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_data  = data_q;

`ifdef LCD_BACKLIGHT_EN
  assign lcd_blon = init_done;
`endif

endmodule

// File: tb/tb_lcd_power_seq.sv
// Bench for lcd_power_seq: directed timing sequences, a write table, and a
// randomized run against a timeline reference model.
module tb_lcd_power_seq;
  localparam int PWR  = 100;
  localparam int EN   = 4;
  localparam int CMD  = 10;
  localparam int LONG = 50;

  logic       clk = 1'b0;
  logic       reset, lcd_on_req, cmd_valid, cmd_rs;
  logic [7:0] cmd_data;
  logic       cmd_ready, init_done, lcd_on, lcd_en, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;
`ifdef LCD_BACKLIGHT_EN
  logic       lcd_blon;
`endif
  logic [13:0] dut_o;

  int checks = 0;
  int errors = 0;

  lcd_power_seq #(
    .POWERUP_CYC (PWR),
    .EN_HIGH_CYC (EN),
    .CMD_GAP_CYC (CMD),
    .LONG_GAP_CYC(LONG)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .lcd_on_req(lcd_on_req),
    .cmd_valid (cmd_valid),
    .cmd_rs    (cmd_rs),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .init_done (init_done),
    .lcd_on    (lcd_on),
    .lcd_en    (lcd_en),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
`ifdef LCD_BACKLIGHT_EN
    .lcd_blon  (lcd_blon),
`endif
    .lcd_data  (lcd_data)
  );

  always #5 clk = ~clk;

  assign dut_o = {cmd_ready, init_done, lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_data};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called right after the edge where lcd_on rose; follows the whole init.
  task automatic run_init(input string tag);
    int k, nstr, first_en, done_k, rdy_k, hi;
    logic prev_en;
    logic [7:0] bytes [4];
    logic rss [4];
    int widths [4];
    logic [7:0] exp_b [4];
    exp_b = '{8'h38, 8'h0C, 8'h01, 8'h06};
    k = 0; nstr = 0; first_en = -1; done_k = -1; rdy_k = -1; hi = 0; prev_en = 1'b0;
    for (int i = 0; i < 4; i++) begin bytes[i] = '0; rss[i] = 1'b1; widths[i] = 0; end
    while (k < 400 && done_k < 0) begin
      step();
      k++;
      if (lcd_en && !prev_en) begin
        if (first_en < 0) first_en = k;
        if (nstr < 4) begin bytes[nstr] = lcd_data; rss[nstr] = lcd_rs; end
        hi = 0;
      end
      if (lcd_en) hi++;
      if (!lcd_en && prev_en) begin
        if (nstr < 4) widths[nstr] = hi;
        nstr++;
      end
      prev_en = lcd_en;
      if (init_done && done_k < 0) done_k = k;
      if (cmd_ready && rdy_k < 0) rdy_k = k;
    end
    check({tag, "_first_en_rise"}, first_en, PWR + 1);
    check({tag, "_strobe_count"}, nstr, 4);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_init_byte"}, bytes[i], exp_b[i]);
      check({tag, "_init_rs"}, rss[i], 0);
      check({tag, "_init_en_width"}, widths[i], EN);
    end
    check({tag, "_init_done_rise"}, done_k, 200);
    check({tag, "_cmd_ready_rise"}, rdy_k, 200);
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         exp_low;
  } wr_t;

  // Timeline reference model: time counted in edges since lcd_on rose.
  bit         m_on, m_busy, m_done, m_rs;
  int         m_t, m_ws, m_gap, m_ninit;
  logic [7:0] m_data;
  logic [7:0] init_list [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  task automatic model_off();
    m_on = 0; m_busy = 0; m_done = 0; m_rs = 0;
    m_t = 0; m_ws = 0; m_gap = 0; m_ninit = 0; m_data = '0;
  endtask

  task automatic model_start(input bit rs, input logic [7:0] d, input bit is_init);
    m_busy = 1; m_ws = m_t; m_rs = rs; m_data = d;
    m_gap = (!rs && (d == 8'h01 || d == 8'h02)) ? LONG : CMD;
    if (is_init) m_ninit++;
  endtask

  task automatic model_edge();
    bit rdy;
    if (!lcd_on_req) model_off();
    else if (!m_on) begin
      m_on = 1; m_t = 0;
    end else begin
      rdy = m_done && !m_busy;
      m_t++;
      if (rdy && cmd_valid) model_start(cmd_rs, cmd_data, 0);
      else if (m_busy && (m_t - m_ws) == 1 + EN + m_gap) begin
        m_busy = 0;
        if (!m_done) begin
          if (m_ninit == 4) m_done = 1;
          else model_start(0, init_list[m_ninit], 1);
        end
      end else if (!m_busy && !m_done && m_ninit == 0 && m_t == PWR)
        model_start(0, init_list[0], 1);
    end
  endtask

  function automatic logic [13:0] model_out();
    logic en;
    en = m_on && m_busy && (m_t - m_ws) >= 1 && (m_t - m_ws) <= EN;
    return {m_on && m_done && !m_busy, m_on && m_done, m_on, en, m_rs, 1'b0, m_data};
  endfunction

  initial begin
    wr_t tbl [8];
    int low, hi, seen_ready;
    logic [7:0] cap_d;
    logic cap_rs, done_drop;

    tbl[0] = '{1'b1, 8'h41, 15};
    tbl[1] = '{1'b0, 8'h01, 55};
    tbl[2] = '{1'b0, 8'h02, 55};
    tbl[3] = '{1'b1, 8'h01, 15};
    tbl[4] = '{1'b1, 8'h02, 15};
    tbl[5] = '{1'b0, 8'h03, 15};
    tbl[6] = '{1'b0, 8'h00, 15};
    tbl[7] = '{1'b0, 8'h38, 15};

    reset = 1'b1; lcd_on_req = 1'b1; cmd_valid = 1'b0; cmd_rs = 1'b0; cmd_data = '0;
    repeat (3) step();
    check("reset_outputs", dut_o, 0);
    reset = 1'b0;
    step();
    check("lcd_on_after_release", lcd_on, 1);
    run_init("init1");

    // back-to-back writes with valid held high
    done_drop = 1'b0;
    foreach (tbl[i]) begin
      cmd_valid = 1'b1; cmd_rs = tbl[i].rs; cmd_data = tbl[i].data;
      check("pre_write_ready", cmd_ready, 1);
      step();
      cmd_rs = ~tbl[i].rs; cmd_data = ~tbl[i].data;
      low = 0; hi = 0; cap_d = '0; cap_rs = 1'b0;
      while (!cmd_ready && low < 200) begin
        if (lcd_en) begin hi++; cap_d = lcd_data; cap_rs = lcd_rs; end
        if (!init_done) done_drop = 1'b1;
        low++;
        step();
      end
      check("wr_ready_low_cycles", low, tbl[i].exp_low);
      check("wr_en_width", hi, EN);
      check("wr_bus_data", cap_d, tbl[i].data);
      check("wr_bus_rs", cap_rs, tbl[i].rs);
    end
    cmd_valid = 1'b0;
    check("init_done_held_in_writes", done_drop, 0);

    // power-down in the middle of a strobe
    cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h55;
    step();
    cmd_valid = 1'b0;
    step();
    check("strobe_active_before_drop", lcd_en, 1);
    lcd_on_req = 1'b0;
    step();
    check("outputs_after_drop", dut_o, 0);
    lcd_on_req = 1'b1;
    step();
    check("lcd_on_after_reraise", lcd_on, 1);
    run_init("init2");

    // asynchronous reset between edges in GAP
    cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h77;
    step();
    cmd_valid = 1'b0;
    repeat (EN + 3) step();
    check("in_gap_bus", {lcd_en, lcd_rs, lcd_data}, {2'b01, 8'h77});
    #2 reset = 1'b1;
    #1 check("async_reset_outputs", dut_o, 0);
    repeat (2) step();
    check("reset_held_outputs", dut_o, 0);
    reset = 1'b0;
    step();
    check("lcd_on_after_async_reset", lcd_on, 1);
    run_init("init3");

    // randomized run against the reference model
    reset = 1'b1; lcd_on_req = 1'b0; cmd_valid = 1'b0;
    step();
    model_off();
    reset = 1'b0;
    seen_ready = 0;
    for (int c = 0; c < 8000; c++) begin
      @(posedge clk);
      model_edge();
      #1;
      check("rand_outputs", dut_o, model_out());
`ifdef LCD_BACKLIGHT_EN
      check("rand_blon", lcd_blon, m_on && m_done);
`endif
      if (cmd_ready) seen_ready++;
      if (lcd_on_req) lcd_on_req = ($urandom_range(0, 599) != 0);
      else lcd_on_req = ($urandom_range(0, 4) == 0);
      cmd_valid = $urandom_range(0, 1);
      cmd_rs = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: cmd_data = 8'h01;
        1: cmd_data = 8'h02;
        default: cmd_data = 8'($urandom_range(0, 255));
      endcase
    end
    check("rand_reached_ready", seen_ready > 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
